tlb_op_ctrl: RTL and testbench

Sequences the MIPS TLB maintenance instructions (TLBP, TLBR, TLBWI) retired at write-back against the shared 16-entry TLB and the CP0 Index/EntryHi/EntryLo0/EntryLo1 registers. It accepts one op per handshake and snapshots the CP0 operands at accept. It drives the TLB search/read/write ports and returns CP0 update strobes. After mapping-changing ops it raises a one-cycle refetch flush to the front end.

---
 rtl/tlb_op_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_tlb_op_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_op_ctrl.sv
// Sequences TLBP/TLBR/TLBWI against the shared TLB and CP0 Index/EntryHi/EntryLo0/EntryLo1.
// Optional TLB_RANDOM_EN: adds a Random counter, cp0_random output, and TLBWR on op_type 3.
module tlb_op_ctrl #(
  parameter int TLBNUM = 16,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [1:0]        op_type,
  input  logic [31:0]       op_pc,
  input  logic [31:0]       cp0_index,
  input  logic [31:0]       cp0_entryhi,
  input  logic [31:0]       cp0_entrylo0,
  input  logic [31:0]       cp0_entrylo1,
  output logic [18:0]       s_vpn2,
  output logic              s_odd_page,
  output logic [7:0]        s_asid,
  input  logic              s_found,
  input  logic [IDX_W-1:0]  s_index,
  output logic [IDX_W-1:0]  r_index,
  input  logic [77:0]       r_entry,
  output logic              we,
  output logic [IDX_W-1:0]  w_index,
  output logic [77:0]       w_entry,
  output logic              cp0_index_we,
  output logic [31:0]       cp0_index_wdata,
  output logic              cp0_tlbr_we,
  output logic [31:0]       cp0_entryhi_wdata,
  output logic [31:0]       cp0_entrylo0_wdata,
  output logic [31:0]       cp0_entrylo1_wdata,
  output logic              busy,
  output logic              done,
  output logic              flush,
`ifdef TLB_RANDOM_EN
  output logic [IDX_W-1:0]  cp0_random,
`endif
  output logic [31:0]       flush_pc
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PROBE    = 3'd1;
  localparam logic [2:0] S_PROBE_WB = 3'd2;
  localparam logic [2:0] S_READ     = 3'd3;
  localparam logic [2:0] S_WRITE    = 3'd4;
  localparam logic [2:0] S_FLUSH    = 3'd5;

  logic [2:0]       r_state;
  logic [2:0]       w_nxt_state;
  logic [31:0]      r_pc;
  logic [18:0]      r_vpn2;
  logic [7:0]       r_asid;
  logic [IDX_W-1:0] r_snap_idx;
  logic [IDX_W-1:0] r_widx;
  logic [25:0]      r_lo0;
  logic [25:0]      r_lo1;
  logic             r_found;
  logic [IDX_W-1:0] r_hit_idx;
  logic             w_accept;
  logic             w_run;
  logic [IDX_W-1:0] w_acc_widx;

  // CP0 fields the TLB has no storage for (PageMask-like holes, upper Index bits).
  logic w_unused_bits;
  assign w_unused_bits = ^{cp0_index[31:IDX_W], cp0_entryhi[12:8],
                           cp0_entrylo0[31:26], cp0_entrylo1[31:26]};

  assign w_run    = !reset;
  assign op_ready = reset || (r_state == S_IDLE);
  assign busy     = !op_ready;
  assign w_accept = w_run && op_valid && (r_state == S_IDLE);

`ifdef TLB_RANDOM_EN
  logic [IDX_W-1:0] r_random;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_random <= IDX_W'(TLBNUM - 1);
    end else if (r_random == '0) begin
      r_random <= IDX_W'(TLBNUM - 1);
    end else begin
      r_random <= r_random - IDX_W'(1);
    end
  end

  assign cp0_random = w_run ? r_random : '0;
  assign w_acc_widx = (op_type == 2'd3) ? r_random : cp0_index[IDX_W-1:0];
`else
  assign w_acc_widx = cp0_index[IDX_W-1:0];
`endif

  always_comb begin
    w_nxt_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (op_valid) begin
          case (op_type)
            2'd0:    w_nxt_state = S_PROBE;
            2'd1:    w_nxt_state = S_READ;
            2'd2:    w_nxt_state = S_WRITE;
`ifdef TLB_RANDOM_EN
            default: w_nxt_state = S_WRITE;
`else
            default: w_nxt_state = S_FLUSH;
`endif
          endcase
        end
      end
      S_PROBE:    w_nxt_state = S_PROBE_WB;
      S_PROBE_WB: w_nxt_state = S_IDLE;
      S_READ:     w_nxt_state = S_FLUSH;
      S_WRITE:    w_nxt_state = S_FLUSH;
      S_FLUSH:    w_nxt_state = S_IDLE;
      default:    w_nxt_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_pc       <= '0;
      r_vpn2     <= '0;
      r_asid     <= '0;
      r_snap_idx <= '0;
      r_widx     <= '0;
      r_lo0      <= '0;
      r_lo1      <= '0;
      r_found    <= 1'b0;
      r_hit_idx  <= '0;
    end else begin
      r_state <= w_nxt_state;
      // Operands are frozen here so write-back may move on while the op runs.
      if (w_accept) begin
        r_pc       <= op_pc;
        r_vpn2     <= cp0_entryhi[31:13];
        r_asid     <= cp0_entryhi[7:0];
        r_snap_idx <= cp0_index[IDX_W-1:0];
        r_widx     <= w_acc_widx;
        r_lo0      <= cp0_entrylo0[25:0];
        r_lo1      <= cp0_entrylo1[25:0];
      end
      if (r_state == S_PROBE) begin
        r_found   <= s_found;
        r_hit_idx <= s_index;
      end
    end
  end

  always_comb begin
    s_vpn2             = '0;
    s_odd_page         = 1'b0;
    s_asid             = '0;
    r_index            = '0;
    we                 = 1'b0;
    w_index            = '0;
    w_entry            = '0;
    cp0_index_we       = 1'b0;
    cp0_index_wdata    = '0;
    cp0_tlbr_we        = 1'b0;
    cp0_entryhi_wdata  = '0;
    cp0_entrylo0_wdata = '0;
    cp0_entrylo1_wdata = '0;
    done               = 1'b0;
    flush              = 1'b0;
    flush_pc           = '0;
    if (w_run) begin
      case (r_state)
        S_PROBE: begin
          s_vpn2 = r_vpn2;
          s_asid = r_asid;
        end
        S_PROBE_WB: begin
          cp0_index_we    = 1'b1;
          cp0_index_wdata = r_found ? {{(32-IDX_W){1'b0}}, r_hit_idx} : 32'h8000_0000;
          done            = 1'b1;
        end
        S_READ: begin
          r_index            = r_snap_idx;
          cp0_tlbr_we        = 1'b1;
          cp0_entryhi_wdata  = {r_entry[77:59], 5'b0, r_entry[58:51]};
          cp0_entrylo0_wdata = {6'b0, r_entry[49:25], r_entry[50]};
          cp0_entrylo1_wdata = {6'b0, r_entry[24:0], r_entry[50]};
        end
        S_WRITE: begin
          we      = 1'b1;
          w_index = r_widx;
          // Global bit is the AND of both halves' G, as MIPS requires.
          w_entry = {r_vpn2, r_asid, r_lo0[0] & r_lo1[0], r_lo0[25:1], r_lo1[25:1]};
        end
        S_FLUSH: begin
          flush    = 1'b1;
          done     = 1'b1;
          flush_pc = r_pc + 32'd4;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed bench for tlb_op_ctrl with a behavioural 16-entry TLB attached.
module tb_tlb_op_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  logic        op_ready;
  logic [1:0]  op_type;
  logic [31:0] op_pc, cp0_index, cp0_entryhi, cp0_entrylo0, cp0_entrylo1;
  logic [18:0] s_vpn2;
  logic        s_odd_page;
  logic [7:0]  s_asid;
  logic        s_found;
  logic [3:0]  s_index;
  logic [3:0]  r_index;
  logic [77:0] r_entry;
  logic        we;
  logic [3:0]  w_index;
  logic [77:0] w_entry;
  logic        cp0_index_we;
  logic [31:0] cp0_index_wdata;
  logic        cp0_tlbr_we;
  logic [31:0] cp0_entryhi_wdata, cp0_entrylo0_wdata, cp0_entrylo1_wdata;
  logic        busy, done, flush;
  logic [31:0] flush_pc;
`ifdef TLB_RANDOM_EN
  logic [3:0]  cp0_random;
`endif

  logic        preload;
  logic [77:0] tlb [16];
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  tlb_op_ctrl #(.TLBNUM(16), .IDX_W(4)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_type(op_type), .op_pc(op_pc), .cp0_index(cp0_index),
    .cp0_entryhi(cp0_entryhi), .cp0_entrylo0(cp0_entrylo0), .cp0_entrylo1(cp0_entrylo1),
    .s_vpn2(s_vpn2), .s_odd_page(s_odd_page), .s_asid(s_asid),
    .s_found(s_found), .s_index(s_index), .r_index(r_index), .r_entry(r_entry),
    .we(we), .w_index(w_index), .w_entry(w_entry),
    .cp0_index_we(cp0_index_we), .cp0_index_wdata(cp0_index_wdata),
    .cp0_tlbr_we(cp0_tlbr_we), .cp0_entryhi_wdata(cp0_entryhi_wdata),
    .cp0_entrylo0_wdata(cp0_entrylo0_wdata), .cp0_entrylo1_wdata(cp0_entrylo1_wdata),
    .busy(busy), .done(done), .flush(flush),
`ifdef TLB_RANDOM_EN
    .cp0_random(cp0_random),
`endif
    .flush_pc(flush_pc)
  );

  // Entry 5 holds vpn2=0x201 asid=0x05 so EntryHi 0x0040_2005 hits it.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 16; i++) tlb[i] <= '0;
      tlb[5] <= {19'h201, 8'h05, 1'b0, 25'h1, 25'h2};
    end else if (we) begin
      tlb[w_index] <= w_entry;
    end
  end

  always_comb begin
    s_found = 1'b0;
    s_index = '0;
    for (int i = 0; i < 16; i++) begin
      if (!s_found && tlb[i][77:59] == s_vpn2 &&
          (tlb[i][50] || tlb[i][58:51] == s_asid)) begin
        s_found = 1'b1;
        s_index = i[3:0];
      end
    end
  end

  assign r_entry = tlb[r_index];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] t, input logic [31:0] pc, input logic [31:0] idx,
                       input logic [31:0] hi, input logic [31:0] lo0, input logic [31:0] lo1);
    op_type      = t;
    op_pc        = pc;
    cp0_index    = idx;
    cp0_entryhi  = hi;
    cp0_entrylo0 = lo0;
    cp0_entrylo1 = lo1;
    op_valid     = 1'b1;
    step();
    op_valid     = 1'b0;
  endtask

  initial begin
    reset = 1'b1; preload = 1'b1; op_valid = 1'b0; op_type = '0; op_pc = '0;
    cp0_index = '0; cp0_entryhi = '0; cp0_entrylo0 = '0; cp0_entrylo1 = '0;
    step(); step();
    chk("rst_ready", op_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_strobes", {we, cp0_index_we, cp0_tlbr_we, flush, done}, 5'b0);
    reset = 1'b0; preload = 1'b0;
    step();
    chk("idle_ready", op_ready, 1'b1);

    // TLBP hit on entry 5
    issue(2'd0, 32'h100, 32'h0, 32'h0040_2005, 32'h0, 32'h0);
    chk("p_busy", busy, 1'b1);
    chk("p_vpn2", s_vpn2, 19'h201);
    chk("p_asid", s_asid, 8'h05);
    chk("p_done_early", done, 1'b0);
    step();
    chk("p_idx_we", cp0_index_we, 1'b1);
    chk("p_idx_wdata", cp0_index_wdata, 32'h0000_0005);
    chk("p_done", done, 1'b1);
    chk("p_flush", flush, 1'b0);
    step();
    chk("p_ready", op_ready, 1'b1);
    chk("p_idx_we_off", cp0_index_we, 1'b0);

    // TLBP miss
    issue(2'd0, 32'h104, 32'h0, 32'h1234_5000, 32'h0, 32'h0);
    step();
    chk("pm_wdata", cp0_index_wdata, 32'h8000_0000);
    step();

    // TLBWI at index 3 (upper Index bits set, ignored)
    issue(2'd2, 32'h0000_1000, 32'h0000_0013, 32'h0080_6011, 32'h0000_0047, 32'h0000_0087);
    chk("wi_we", we, 1'b1);
    chk("wi_index", w_index, 4'd3);
    chk("wi_entry", w_entry, {19'h403, 8'h11, 1'b1, 25'h23, 25'h43});
    chk("wi_no_done", done, 1'b0);
    step();
    chk("wi_we_once", we, 1'b0);
    chk("wi_flush", flush, 1'b1);
    chk("wi_done", done, 1'b1);
    chk("wi_flush_pc", flush_pc, 32'h0000_1004);
    step();
    chk("wi_flush_off", flush, 1'b0);

    // TLBR at index 3, PC chosen so the refetch target wraps
    issue(2'd1, 32'hFFFF_FFFE, 32'h3, 32'h0, 32'h0, 32'h0);
    chk("r_index", r_index, 4'd3);
    chk("r_we", cp0_tlbr_we, 1'b1);
    chk("r_hi", cp0_entryhi_wdata, 32'h0080_6011);
    chk("r_lo0", cp0_entrylo0_wdata, 32'h0000_0047);
    chk("r_lo1", cp0_entrylo1_wdata, 32'h0000_0087);
    step();
    chk("r_flush", flush, 1'b1);
    chk("r_done", done, 1'b1);
    chk("r_flush_pc", flush_pc, 32'h0000_0002);
    chk("r_we_off", cp0_tlbr_we, 1'b0);
    step();

`ifndef TLB_RANDOM_EN
    // Reserved op: flush only, one cycle after accept
    issue(2'd3, 32'h0000_2000, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("rsv_done", done, 1'b1);
    chk("rsv_flush_pc", flush_pc, 32'h0000_2004);
    chk("rsv_we", we, 1'b0);
    step();
`endif

    // Held request plus CP0 change after accept
    op_type = 2'd0; op_pc = 32'h300; cp0_entryhi = 32'h0040_2005; op_valid = 1'b1;
    step();
    cp0_entryhi = 32'h1234_5000;
    #1;
    chk("hold_ready", op_ready, 1'b0);
    chk("hold_snap_vpn2", s_vpn2, 19'h201);
    step();
    chk("hold_wdata", cp0_index_wdata, 32'h0000_0005);
    step();
    chk("hold_ready2", op_ready, 1'b1);
    step();
    op_valid = 1'b0;
    chk("hold_2nd_vpn2", s_vpn2, 19'h091A2);
    step();
    chk("hold_2nd_wdata", cp0_index_wdata, 32'h8000_0000);
    step();

    // Reset during WRITE
    issue(2'd2, 32'h400, 32'h7, 32'h0040_2005, 32'h1, 32'h1);
    reset = 1'b1;
    #1;
    chk("rw_we", we, 1'b0);
    chk("rw_ready", op_ready, 1'b1);
    step();
    reset = 1'b0;
    #1;
    chk("rw_idle", op_ready, 1'b1);
    chk("rw_strobes", {we, flush, done}, 3'b0);
    step();
    chk("rw_tlb7", tlb[7], 78'h0);

`ifdef TLB_RANDOM_EN
    // TLBWR 20 cycles after reset latches Random = 11
    reset = 1'b1;
    step();
    reset = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("rnd_value", cp0_random, 4'd11);
    issue(2'd3, 32'h500, 32'h2, 32'h0040_2005, 32'h1, 32'h1);
    chk("wr_we", we, 1'b1);
    chk("wr_index", w_index, 4'd11);
    step();
    chk("wr_flush", flush, 1'b1);
    step();
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
